mdu_sequencer: RTL
==================

Name: mdu_sequencer

Overview:
- Iterative multiply/divide unit with its own sequencer. It sits beside the EX-stage ALU of the pipelined CPU and owns the HI/LO registers.
- It accepts mult/multu/div/divu, runs a radix-2 shift-add or shift-subtract loop over 32 cycles, then writes HI/LO.
- It drives stall_o back to the hazard logic whenever the pipeline needs HI/LO or the unit while busy.

Parameters:
- WIDTH, 32, operand width; HI/LO are WIDTH bits each.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W == WIDTH.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  reset, asynchronous, active-low.
- start_i  input  1  EX stage issues an MDU op this cycle.
- op_i  input  2  00 mult, 01 multu, 10 div, 11 divu; sampled with start_i.
- src_a_i  input  WIDTH  rs operand (multiplicand / dividend).
- src_b_i  input  WIDTH  rt operand (multiplier / divisor).
- hi_we_i  input  1  mthi request.
- lo_we_i  input  1  mtlo request.
- wdata_i  input  WIDTH  mthi/mtlo data.
- rd_hilo_i  input  1  mfhi/mflo in EX this cycle.
- flush_i  input  1  abort the in-flight op (branch/exception flush).
- busy_o  output  1  state != IDLE.
- stall_o  output  1  combinational: busy_o & (start_i | rd_hilo_i | hi_we_i | lo_we_i).
- done_o  output  1  one-cycle pulse; HI/LO hold the new result.
- div0_o  output  1  pulses with done_o when the divisor was 0.
- hi_o  output  WIDTH  HI register.
- lo_o  output  WIDTH  LO register.

Behaviour:
- Reset (rst_i=0, any time, including mid-op):
  - State goes to IDLE.
  - hi_o=0, lo_o=0, busy_o=0, done_o=0, div0_o=0.
  - Counter and working registers are cleared.
  - Any in-flight op is lost.
- States:
  - IDLE -> RUN on start_i & !flush_i.
  - RUN -> FIN after 32 iterations (count reaches 31).
  - FIN -> IDLE unconditionally.
  - flush_i in RUN or FIN -> IDLE at the next edge; HI/LO unchanged; done_o stays 0.
- Accept (IDLE, edge E0):
  - Latch op_i.
  - Signed ops: latch |src_a_i| and |src_b_i|, plus the signs sa and sb.
  - Unsigned ops: latch operands as-is.
  - count=0.
- RUN: one iteration per edge, E1..E32.
  - Mult: 2*WIDTH accumulator, shift-add.
  - Div: restoring shift-subtract; remainder WIDTH+1 bits wide.
- FIN (edge E33): write HI/LO, assert done_o in the following cycle, return to IDLE.
  - Total latency: 33 edges after accept.
  - busy_o is high for cycles E0..E33.
- Sign correction (applied at FIN):
  - mult: if sa^sb, negate the 64-bit product. HI = product[63:32], LO = product[31:0].
  - div: LO = quotient, negated if sa^sb. HI = remainder, negated if sa.
  - -2^31 / -1 yields LO=0x80000000, HI=0 (no trap).
- Divide by zero:
  - Same 33-cycle latency.
  - HI=src_a_i as latched (original signed value), LO=0xFFFFFFFF.
  - div0_o=1 with done_o.
- mthi/mtlo:
  - Only while IDLE; the write lands at the next edge.
  - While busy they are held off via stall_o.
  - hi_we_i and lo_we_i may both be 1 in the same cycle.
- Simultaneous events:
  - start_i with hi_we_i/lo_we_i in IDLE: start wins, writes dropped.
  - flush_i with start_i in IDLE: flush wins, no accept.
  - start_i while busy: ignored; stall_o=1.
- rd_hilo_i: stall_o=1 until busy_o falls. hi_o/lo_o are valid in the cycle done_o=1.

Test Plan:
- multu 0xFFFFFFFF x 0xFFFFFFFF -> done_o exactly 34 cycles after start (33 edges), HI=0xFFFFFFFE, LO=0x00000001, busy_o low after.
- mult -3 x 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. Then div -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- divu 10 / 0 -> HI=0x0000000A, LO=0xFFFFFFFF, div0_o=1 for one cycle with done_o.
- Preload HI=0x1234 via mthi; start divu, assert flush_i at cycle 10 -> busy_o low next edge, done_o never pulses, HI still 0x1234.
- Start mult, hold rd_hilo_i=1 -> stall_o=1 every cycle through E33, 0 when done_o=1. mtlo 0x55 while busy -> stalled, LO=0x55 only once issued after idle.
- rst_i low at iteration 20 -> all outputs 0 immediately (asynchronous). New multu 2 x 3 after release -> LO=6, HI=0.

Source files
------------

// File: rtl/mdu_sequencer.sv
// Iterative multiply/divide unit owning HI/LO: radix-2 shift-add multiply and
// restoring shift-subtract divide, 32 iterations per op, with pipeline stall generation.
module mdu_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] src_a_i,
    input  logic [WIDTH-1:0] src_b_i,
    input  logic             hi_we_i,
    input  logic             lo_we_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             rd_hilo_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             stall_o,
    output logic             done_o,
    output logic             div0_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [1:0]         op_r;
    logic               sa;
    logic               sb;
    logic [WIDTH-1:0]   wa;
    logic [WIDTH-1:0]   wb;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   rem;

    function automatic logic [WIDTH-1:0] neg_if(input logic c, input logic [WIDTH-1:0] v);
        return c ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_if_wide(input logic c, input logic [2*WIDTH-1:0] v);
        return c ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [WIDTH-1:0] magnitude(input logic is_signed, input logic signed [WIDTH-1:0] v);
        return neg_if(is_signed & v[WIDTH-1], v);
    endfunction

    // Per-iteration datapath: multiply keeps the multiplier in acc's low half,
    // divide keeps the dividend there and shifts quotient bits in behind it.
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH:0]       div_diff;
    logic                 div_ge;
    logic [2*WIDTH-1:0]   acc_next;
    logic [WIDTH-1:0]     rem_next;
    logic                 is_div;
    logic                 neg_res;
    logic                 div_zero;

    always_comb begin
        is_div    = op_r[1];
        neg_res   = sa ^ sb;
        div_zero  = (wb == '0);
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, wa} : '0);
        div_shift = {rem, acc[WIDTH-1]};
        div_diff  = div_shift - {1'b0, wb};
        div_ge    = (div_shift >= {1'b0, wb});
        acc_next  = '0;
        rem_next  = rem;
        if (is_div) begin
            acc_next = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], div_ge};
            rem_next = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
        end else begin
            acc_next = {mul_sum, acc[WIDTH-1:1]};
        end
    end

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   a_orig;

    always_comb begin
        prod_fix = neg_if_wide(neg_res, acc);
        quo_fix  = neg_if(neg_res, acc[WIDTH-1:0]);
        rem_fix  = neg_if(sa, rem);
        a_orig   = neg_if(sa, wa);
    end

    assign busy_o  = (state != IDLE);
    assign stall_o = busy_o & (start_i | rd_hilo_i | hi_we_i | lo_we_i);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state  <= IDLE;
            cnt    <= '0;
            op_r   <= '0;
            sa     <= 1'b0;
            sb     <= 1'b0;
            wa     <= '0;
            wb     <= '0;
            acc    <= '0;
            rem    <= '0;
            hi_o   <= '0;
            lo_o   <= '0;
            done_o <= 1'b0;
            div0_o <= 1'b0;
        end else begin
            done_o <= 1'b0;
            div0_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i && !flush_i) begin
                        state <= RUN;
                        cnt   <= '0;
                        op_r  <= op_i;
                        sa    <= ~op_i[0] & src_a_i[WIDTH-1];
                        sb    <= ~op_i[0] & src_b_i[WIDTH-1];
                        wa    <= magnitude(~op_i[0], src_a_i);
                        wb    <= magnitude(~op_i[0], src_b_i);
                        rem   <= '0;
                        // Multiply seeds the multiplier, divide seeds the dividend.
                        acc   <= {{WIDTH{1'b0}},
                                  op_i[1] ? magnitude(~op_i[0], src_a_i)
                                          : magnitude(~op_i[0], src_b_i)};
                    end else if (!start_i) begin
                        if (hi_we_i) hi_o <= wdata_i;
                        if (lo_we_i) lo_o <= wdata_i;
                    end
                end
                RUN: begin
                    if (flush_i) begin
                        state <= IDLE;
                    end else begin
                        acc <= acc_next;
                        rem <= rem_next;
                        cnt <= cnt + 1'b1;
                        if (cnt == {CNT_W{1'b1}}) state <= FIN;
                    end
                end
                FIN: begin
                    state <= IDLE;
                    if (!flush_i) begin
                        done_o <= 1'b1;
                        if (!is_div) begin
                            hi_o <= prod_fix[2*WIDTH-1:WIDTH];
                            lo_o <= prod_fix[WIDTH-1:0];
                        end else if (div_zero) begin
                            hi_o   <= a_orig;
                            lo_o   <= '1;
                            div0_o <= 1'b1;
                        end else begin
                            hi_o <= rem_fix;
                            lo_o <= quo_fix;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
